vm_coin_acceptor: RTL and testbench
===================================

Name: vm_coin_acceptor

Overview:
- Upstream stage of the vending FSM.
- Takes one-cycle coin events from the coin mechanism and accumulates the inserted value in cents, plus per-denomination coin counts.
- Presents the accumulated value as dinheiro_inserido and the counts as moedas_inseridas for the sale/change stage.
- Rejects coins that would overflow the value cap, or that arrive outside the acceptance window.
- Raises a refund request when the customer goes idle mid-session.

Parameters:
- MAX_CENTS, 250: maximum accumulated value; must be ≤255 and a multiple of 25.
- TIMEOUT_CYCLES, 1000: idle cycles after the last accepted coin before refund request; must be ≥2.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- accept_en  input  1  acceptance window; high while the vending FSM is in its money-insertion state
- coin_valid  input  1  one-cycle strobe: coin present this cycle
- coin_type  input  2  0=invalid, 1=R$0,25, 2=R$0,50, 3=R$1,00; sampled only when coin_valid=1
- clear  input  1  one-cycle pulse from the vending FSM after a sale or refund completes; empties the accumulator
- dinheiro_inserido  output  8  accumulated value in cents
- moedas_inseridas  output  24  [7:0]=count of 0,25; [15:8]=count of 0,50; [23:16]=count of 1,00
- coin_accepted  output  1  one-cycle pulse: the coin was added
- coin_reject  output  1  one-cycle pulse: the mechanism must return the coin
- session_active  output  1  high while at least one coin is held
- refund_req  output  1  level; high from timeout until clear

Behaviour:
- Reset (async assert, sync deassert by clock): all outputs 0; state IDLE; idle counter 0.
- Coin values: 25, 50, 100 cents. Sum computed 9 bits wide; the accept test is sum ≤ MAX_CENTS.
- Accept condition, evaluated on the edge where coin_valid=1:
  - accept_en=1
  - coin_type≠0
  - state≠TIMEOUT
  - dinheiro_inserido+value ≤ MAX_CENTS
  - selected count field <255
- On accept:
  - dinheiro_inserido and the matching count update at that edge, so they are visible the next cycle (latency 1).
  - coin_accepted pulses in the same next cycle.
  - Idle counter reloads to 0.
- Otherwise (coin_valid=1 but condition fails): coin_reject pulses for 1 cycle; totals unchanged.
- coin_valid=0: no pulse; coin_type ignored.
- States:
  - IDLE: dinheiro_inserido=0. An accepted coin moves to COLLECTING.
  - COLLECTING: the idle counter increments every cycle without an accepted coin. When it reaches TIMEOUT_CYCLES-1, go to TIMEOUT and set refund_req=1.
  - TIMEOUT: every coin is rejected; totals are held so the refund path can return exactly moedas_inseridas; refund_req stays 1.
- clear:
  - Returns to IDLE from any state and zeroes dinheiro_inserido, moedas_inseridas, refund_req and the idle counter at the next edge.
  - clear has priority over a simultaneous coin_valid; that coin is rejected (coin_reject=1), not lost.
- accept_en low while in COLLECTING: totals are held; the idle counter keeps running, so timeout still applies.
- Cap boundary: exactly reaching MAX_CENTS is accepted; one unit over is rejected.
- session_active = (state≠IDLE); registered.
- Reset mid-session discards totals without a refund_req. The vending FSM is reset by the same reset_n.

Decomposition:
- Shared package vm_pkg:
  - coin type codes: COIN_NONE, COIN_25, COIN_50, COIN_100
  - coin values in cents
  - count field slice positions for the 24-bit coin vector
  - 8-bit cents width
  - acceptor state enum (IDLE, COLLECTING, TIMEOUT)
- One sub-module: vm_idle_timer, a loadable counter with clear/reload inputs and a terminal pulse at TIMEOUT_CYCLES-1.
- Everything else stays in vm_coin_acceptor.

Test Plan:
- Reset, then accept_en=1; coins 25, 50, 100 on separate cycles -> dinheiro_inserido 25→75→175; moedas_inseridas=0x010101; three coin_accepted pulses; no reject.
- Total 200, then a 100 coin (MAX_CENTS=250) -> coin_reject pulse, total stays 200. Then a 50 coin -> accepted, total=250 exactly.
- accept_en=0 with coin_valid, type 2 -> coin_reject; total 0; session_active stays 0. Also coin_type=0 with accept_en=1 -> coin_reject.
- TIMEOUT_CYCLES=10; accept one 50 coin, then idle -> refund_req rises 10 cycles after the coin's accept edge. A subsequent 25 coin -> rejected; totals held at 50/0x000100. clear -> all zero next cycle, state IDLE.
- clear and coin_valid(type 3) on the same cycle, with total 75 -> next cycle total 0, coin_reject=1, coin_accepted=0.
- Assert reset_n low mid-cycle with total 150 -> outputs go to 0 immediately, without waiting for a clock edge; after release, a 25 coin gives total 25.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and constants for the vending machine coin path.
package vm_pkg;
  localparam int CENTS_W   = 8;
  localparam int CNT_W     = 8;
  localparam int NUM_DENOM = 3;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_25   = 2'd1,
    COIN_50   = 2'd2,
    COIN_100  = 2'd3
  } coin_t;

  localparam logic [CENTS_W-1:0] VAL_25  = 8'd25;
  localparam logic [CENTS_W-1:0] VAL_50  = 8'd50;
  localparam logic [CENTS_W-1:0] VAL_100 = 8'd100;

  // Count field positions inside the 24-bit coin vector
  localparam int CNT25_LSB  = 0;
  localparam int CNT50_LSB  = 8;
  localparam int CNT100_LSB = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COLLECTING = 2'd1,
    TIMEOUT    = 2'd2
  } acc_state_t;

  function automatic logic [CENTS_W-1:0] coin_value(input coin_t t);
    case (t)
      COIN_25:  coin_value = VAL_25;
      COIN_50:  coin_value = VAL_50;
      COIN_100: coin_value = VAL_100;
      default:  coin_value = '0;
    endcase
  endfunction
endpackage

// File: rtl/vm_coin_acceptor_if.sv
// Coin acceptor handshake: controls from the vending FSM, totals back to it.
interface vm_coin_acceptor_if;
  import vm_pkg::*;
  logic                         accept_en;
  logic                         coin_valid;
  logic [1:0]                   coin_type;
  logic                         clear;
  logic [CENTS_W-1:0]           dinheiro_inserido;
  logic [NUM_DENOM*CNT_W-1:0]   moedas_inseridas;
  logic                         coin_accepted;
  logic                         coin_reject;
  logic                         session_active;
  logic                         refund_req;

  modport master (
    output accept_en, coin_valid, coin_type, clear,
    input  dinheiro_inserido, moedas_inseridas, coin_accepted,
           coin_reject, session_active, refund_req
  );
  modport slave (
    input  accept_en, coin_valid, coin_type, clear,
    output dinheiro_inserido, moedas_inseridas, coin_accepted,
           coin_reject, session_active, refund_req
  );
endinterface

// File: rtl/vm_idle_timer.sv
// Idle counter: clear/reload to zero, counts while enabled, flags TIMEOUT_CYCLES-1.
module vm_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic reload,
  input  logic enable,
  output logic terminal
);
  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  assign terminal = (count == W'(TIMEOUT_CYCLES - 1));

  // Holds at the terminal value so the count never wraps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                count <= '0;
    else if (clear || reload)    count <= '0;
    else if (enable && !terminal) count <= count + 1'b1;
  end
endmodule

// File: rtl/vm_coin_acceptor.sv
// Coin acceptor: accumulates accepted coins, rejects over-cap/out-of-window coins,
// and requests a refund when the customer stalls mid-session.
module vm_coin_acceptor
  import vm_pkg::*;
#(
  parameter int MAX_CENTS      = 250,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  vm_coin_acceptor_if.slave    bus
);
  logic [1:0]         rst_sync;
  logic               rst_n_int;
  acc_state_t         state;
  logic [CENTS_W-1:0] total;
  logic [NUM_DENOM-1:0][CNT_W-1:0] counts;
  logic [CENTS_W:0]   sum;
  logic [CNT_W-1:0]   sel_cnt;
  logic               accept, reject, timer_term;
  coin_t              ctype;

  // Asynchronous assert, release aligned to the clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign ctype = coin_t'(bus.coin_type);
  assign sum   = {1'b0, total} + {1'b0, coin_value(ctype)};

  always_comb begin
    sel_cnt = '0;
    case (ctype)
      COIN_25:  sel_cnt = counts[0];
      COIN_50:  sel_cnt = counts[1];
      COIN_100: sel_cnt = counts[2];
      default:  sel_cnt = '0;
    endcase
  end

  // clear wins over a coin in the same cycle; that coin goes back to the customer
  assign accept = bus.coin_valid && bus.accept_en && (ctype != COIN_NONE) &&
                  (state != TIMEOUT) && !bus.clear &&
                  (sum <= (CENTS_W+1)'(MAX_CENTS)) && (sel_cnt != {CNT_W{1'b1}});
  assign reject = bus.coin_valid && !accept;

  vm_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock    (clock),
    .reset_n  (rst_n_int),
    .clear    (bus.clear),
    .reload   (accept),
    .enable   (state == COLLECTING),
    .terminal (timer_term)
  );

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state              <= IDLE;
      total              <= '0;
      bus.coin_accepted  <= 1'b0;
      bus.coin_reject    <= 1'b0;
      bus.session_active <= 1'b0;
      bus.refund_req     <= 1'b0;
    end else begin
      bus.coin_accepted <= accept;
      bus.coin_reject   <= reject;
      if (bus.clear) begin
        state              <= IDLE;
        total              <= '0;
        bus.session_active <= 1'b0;
        bus.refund_req     <= 1'b0;
      end else if (accept) begin
        state              <= COLLECTING;
        total              <= sum[CENTS_W-1:0];
        bus.session_active <= 1'b1;
      end else if (state == COLLECTING && timer_term) begin
        state          <= TIMEOUT;
        bus.refund_req <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_DENOM; g++) begin : g_cnt
    always_ff @(posedge clock or negedge rst_n_int) begin
      if (!rst_n_int)                                     counts[g] <= '0;
      else if (bus.clear)                                 counts[g] <= '0;
      else if (accept && (ctype == coin_t'(2'(g + 1))))   counts[g] <= counts[g] + 1'b1;
    end
  end

  assign bus.dinheiro_inserido = total;
  assign bus.moedas_inseridas  = {counts[2], counts[1], counts[0]};
endmodule

// File: tb/tb_vm_coin_acceptor.sv
// Bench for vm_coin_acceptor: vector table, corner sequences, random vs. model.
module tb_vm_coin_acceptor;
  localparam int MAXC = 250;
  localparam int TMO  = 10;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  vm_coin_acceptor_if bus();

  vm_coin_acceptor #(.MAX_CENTS(MAXC), .TIMEOUT_CYCLES(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: running total, per-value counts, cycles since last accept
  int m_total, m_idle;
  int m_cnt [4];
  bit m_sess, m_ref, m_acc, m_rej;

  function automatic void model_reset();
    m_total = 0; m_idle = 0; m_sess = 0; m_ref = 0; m_acc = 0; m_rej = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endfunction

  function automatic void model_step(bit en, bit cv, int t, bit clr);
    int vals [4] = '{0, 25, 50, 100};
    bit ok;
    ok = cv && en && t != 0 && !m_ref && !clr &&
         (m_total + vals[t] <= MAXC) && (m_cnt[t] < 255);
    m_acc = ok;
    m_rej = cv && !ok;
    if (clr) begin
      m_total = 0; m_idle = 0; m_sess = 0; m_ref = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (ok) begin
      m_total += vals[t]; m_cnt[t]++; m_sess = 1; m_idle = 0;
    end else if (m_sess && !m_ref) begin
      m_idle++;
      if (m_idle >= TMO) m_ref = 1;
    end
  endfunction

  function automatic int model_moedas();
    return (m_cnt[3] << 16) | (m_cnt[2] << 8) | m_cnt[1];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $time, act, act, exp, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".total"},    int'(bus.dinheiro_inserido), m_total);
    chk({tag, ".moedas"},   int'(bus.moedas_inseridas),  model_moedas());
    chk({tag, ".accepted"}, int'(bus.coin_accepted),     int'(m_acc));
    chk({tag, ".reject"},   int'(bus.coin_reject),       int'(m_rej));
    chk({tag, ".session"},  int'(bus.session_active),    int'(m_sess));
    chk({tag, ".refund"},   int'(bus.refund_req),        int'(m_ref));
  endtask

  // Drive one cycle of inputs, advance model, sample 1 ns after the edge
  task automatic step(input bit en, input bit cv, input int t, input bit clr, input string tag);
    bus.accept_en  = en;
    bus.coin_valid = cv;
    bus.coin_type  = 2'(t);
    bus.clear      = clr;
    model_step(en, cv, t, clr);
    @(posedge clock);
    #1;
    chk_model(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b0, "idle");
  endtask

  typedef struct {
    bit        en, cv;
    int        t;
    bit        clr;
    int        tot;
    int        moe;
    bit        acc, rej, ses, rf;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1, 1, 1, 0,  25, 'h000001, 1, 0, 1, 0};
    vecs[1]  = '{1, 1, 2, 0,  75, 'h000101, 1, 0, 1, 0};
    vecs[2]  = '{1, 1, 3, 0, 175, 'h010101, 1, 0, 1, 0};
    vecs[3]  = '{1, 0, 0, 1,   0, 'h000000, 0, 0, 0, 0};
    vecs[4]  = '{1, 1, 3, 0, 100, 'h010000, 1, 0, 1, 0};
    vecs[5]  = '{1, 1, 3, 0, 200, 'h020000, 1, 0, 1, 0};
    vecs[6]  = '{1, 1, 3, 0, 200, 'h020000, 0, 1, 1, 0};
    vecs[7]  = '{1, 1, 2, 0, 250, 'h020100, 1, 0, 1, 0};
    vecs[8]  = '{1, 1, 1, 0, 250, 'h020100, 0, 1, 1, 0};
    vecs[9]  = '{1, 0, 0, 1,   0, 'h000000, 0, 0, 0, 0};
    vecs[10] = '{0, 1, 2, 0,   0, 'h000000, 0, 1, 0, 0};
    vecs[11] = '{1, 1, 0, 0,   0, 'h000000, 0, 1, 0, 0};
    vecs[12] = '{0, 0, 3, 0,   0, 'h000000, 0, 0, 0, 0};

    bus.accept_en = 0; bus.coin_valid = 0; bus.coin_type = 0; bus.clear = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk_model("reset");
    reset_n = 1'b1;
    idle(3);

    for (int i = 0; i < 13; i++) begin
      string tg;
      tg = $sformatf("vec%0d", i);
      step(vecs[i].en, vecs[i].cv, vecs[i].t, vecs[i].clr, tg);
      chk({tg, ".tbl_total"},  int'(bus.dinheiro_inserido), vecs[i].tot);
      chk({tg, ".tbl_moedas"}, int'(bus.moedas_inseridas),  vecs[i].moe);
      chk({tg, ".tbl_acc"},    int'(bus.coin_accepted),     int'(vecs[i].acc));
      chk({tg, ".tbl_rej"},    int'(bus.coin_reject),       int'(vecs[i].rej));
      chk({tg, ".tbl_sess"},   int'(bus.session_active),    int'(vecs[i].ses));
      chk({tg, ".tbl_refund"}, int'(bus.refund_req),        int'(vecs[i].rf));
    end

    // Timeout: refund appears exactly TMO cycles after the accept edge
    step(1, 1, 2, 0, "tmo_coin");
    for (int i = 1; i < TMO; i++) begin
      step(1, 0, 0, 0, "tmo_wait");
      chk("tmo_early_refund", int'(bus.refund_req), 0);
    end
    step(1, 0, 0, 0, "tmo_hit");
    chk("tmo_refund", int'(bus.refund_req), 1);
    step(1, 1, 1, 0, "tmo_coin25");
    chk("tmo_rej", int'(bus.coin_reject), 1);
    chk("tmo_hold_total", int'(bus.dinheiro_inserido), 50);
    chk("tmo_hold_moedas", int'(bus.moedas_inseridas), 'h000100);
    step(1, 0, 0, 1, "tmo_clear");
    chk("tmo_clr_refund", int'(bus.refund_req), 0);
    chk("tmo_clr_sess", int'(bus.session_active), 0);

    // clear collides with a coin: coin rejected, totals emptied
    step(1, 1, 1, 0, "cc_a");
    step(1, 1, 2, 0, "cc_b");
    step(1, 1, 3, 1, "cc_clear");
    chk("cc_total", int'(bus.dinheiro_inserido), 0);
    chk("cc_rej", int'(bus.coin_reject), 1);
    chk("cc_acc", int'(bus.coin_accepted), 0);

    // Asynchronous reset mid-cycle with a session open
    step(1, 1, 3, 0, "ar_a");
    step(1, 1, 2, 0, "ar_b");
    chk("ar_pre_total", int'(bus.dinheiro_inserido), 150);
    bus.coin_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_model("ar_async");
    #3 reset_n = 1'b1;
    idle(3);
    step(1, 1, 1, 0, "ar_after");
    chk("ar_after_total", int'(bus.dinheiro_inserido), 25);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit en, cv, clr;
      en  = ($urandom_range(0, 9) != 0);
      cv  = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 39) == 0);
      step(en, cv, int'($urandom_range(0, 3)), clr, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
